// File: rtl/csd_shift_add_mult.sv
// Serial CSD multiplier: product = x_in * (csd_pos - csd_neg), one digit per clock.
// Fixed N-cycle scan so latency is independent of the coefficient's digit pattern.
module csd_shift_add_mult #(
    parameter int N  = 8,
    parameter int XW = 8,
    parameter int PW = XW + N + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [XW-1:0]              x_in,
    input  logic [N-1:0]               csd_pos,
    input  logic [N-1:0]               csd_neg,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [PW-1:0]              product,
    output logic [$clog2(N+1)-1:0]     nz_count
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // A digit cannot be both +1 and -1; any overlap makes the coefficient invalid.
    function automatic logic has_overlap(input logic [N-1:0] p, input logic [N-1:0] n);
        return |(p & n);
    endfunction

    logic [1:0]    state_q,   state_d;
    logic [PW-1:0] x_q,       x_d;
    logic [N-1:0]  pos_q,     pos_d;
    logic [N-1:0]  neg_q,     neg_d;
    logic [PW-1:0] acc_q,     acc_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic [PW-1:0] product_q, product_d;
    logic [CW-1:0] nz_q,      nz_d;
    logic [PW-1:0] term_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        product_d = product_q;
        nz_d      = nz_q;
        term_s    = x_q << idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d   = {{(PW-XW){x_in[XW-1]}}, x_in};
                    pos_d = csd_pos;
                    neg_d = csd_neg;
                    acc_d = {PW{1'b0}};
                    idx_d = {IW{1'b0}};
                    cnt_d = {CW{1'b0}};
                    if (has_overlap(csd_pos, csd_neg)) begin
                        state_d   = ST_ERR;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        product_d = {PW{1'b0}};
                        nz_d      = {CW{1'b0}};
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (pos_q[idx_q]) begin
                    acc_d = acc_q + term_s;
                    cnt_d = cnt_q + CNT_ONE;
                end else if (neg_q[idx_q]) begin
                    acc_d = acc_q - term_s;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    acc_d = acc_q;
                    cnt_d = cnt_q;
                end
                // Result and count are published together with the done pulse.
                if (idx_q == IDX_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    product_d = acc_d;
                    nz_d      = cnt_d;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x_q       <= {PW{1'b0}};
            pos_q     <= {N{1'b0}};
            neg_q     <= {N{1'b0}};
            acc_q     <= {PW{1'b0}};
            idx_q     <= {IW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            product_q <= {PW{1'b0}};
            nz_q      <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            product_q <= product_d;
            nz_q      <= nz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign product  = product_q;
    assign nz_count = nz_q;

endmodule
